rf_access_arbiter: RTL

Shares the single-port register file (one address bus, one write strobe, registered read output) between NREQ requesters. Each requester issues read or write commands through a valid/ready handshake and receives a one-cycle response pulse. The block sits between requester logic (bus bridge, test sequencer, datapath control) and the register file's CLK/RESET/ENABLE/WR/ADD_WR/DATAIN/OUT1 pins. It serialises accesses so that exactly one operation is in flight at any time.

---
 rtl/rf_access_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter
//
// Shares a single-port register file between NREQ requesters. Each command
// goes through a valid/ready handshake in IDLE, is presented to the register
// file for one cycle in ISSUE, and is answered with a one-cycle response
// pulse in RESP. Only one operation is ever in flight.
//
// Build option:
//   RFARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration (pointer reg)
//                         undefined -> fixed priority, lowest index wins
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   REQ_VALID/READY       per-requester command handshake (READY is comb)
//   REQ_WR                per-requester op (1 = write, 0 = read)
//   REQ_ADDR, REQ_WDATA   flattened per-requester address / write data
//   RSP_VALID             one-cycle response pulse to the granted requester
//   RSP_RDATA             shared read-data bus (0 for writes / no response)
//   BUSY                  high while an operation is in flight
//   RF_EN/WR/ADDR/DIN     register file ENABLE / WR / ADD_WR / DATAIN
//   RF_DOUT               register file OUT1 (registered read output)
// ---------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int NBIT  = 64,
  parameter int NADDR = 4,
  parameter int NREQ  = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        REQ_VALID,
  output logic [NREQ-1:0]        REQ_READY,
  input  logic [NREQ-1:0]        REQ_WR,
  input  logic [NREQ*NADDR-1:0]  REQ_ADDR,
  input  logic [NREQ*NBIT-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]        RSP_VALID,
  output logic [NBIT-1:0]        RSP_RDATA,
  output logic                   BUSY,
  output logic                   RF_EN,
  output logic                   RF_WR,
  output logic [NADDR-1:0]       RF_ADDR,
  output logic [NBIT-1:0]        RF_DIN,
  input  logic [NBIT-1:0]        RF_DOUT
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [NADDR-1:0]  addr_q, addr_d;
  logic [NBIT-1:0]   wdata_q, wdata_d;

  logic [GW-1:0]     win_idx;
  logic              win_any;
  logic              hs;

`ifdef RFARB_ROUND_ROBIN_EN
  logic [GW-1:0]     ptr_q, ptr_d;

  // Search starts at the pointer and wraps, so the last winner drops to
  // lowest priority on the next arbitration.
  always_comb begin
    int idx;
    win_idx = '0;
    win_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_any && REQ_VALID[idx]) begin
        win_any = 1'b1;
        win_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + GW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_any && REQ_VALID[k]) begin
        win_any = 1'b1;
        win_idx = GW'(k);
      end
    end
  end
`endif

  // A grant is only offered in IDLE; the winner's VALID is set by
  // construction, so an offered grant is always a handshake.
  assign hs        = (state_q == IDLE) && win_any;
  assign REQ_READY = hs ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          gnt_d   = win_idx;
          wr_d    = REQ_WR[win_idx];
          addr_d  = REQ_ADDR[win_idx*NADDR +: NADDR];
          wdata_d = REQ_WDATA[win_idx*NBIT +: NBIT];
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The register file acts on the edge that ends ISSUE; its registered
  // output is therefore valid during RESP, where it is forwarded.
  assign RF_EN     = (state_q == ISSUE);
  assign RF_WR     = (state_q == ISSUE) && wr_q;
  assign RF_ADDR   = addr_q;
  assign RF_DIN    = wdata_q;
  assign BUSY      = (state_q != IDLE);
  assign RSP_VALID = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign RSP_RDATA = ((state_q == RESP) && !wr_q) ? RF_DOUT : '0;

endmodule
